// File: rtl/ag6502_pkg.sv
// Shared ALU definitions: op encodings (matching the core's ALU_* values) and
// the serial ALU sequencing states.
package ag6502_pkg;

  localparam logic [2:0] ALU_ORA = 3'd0;
  localparam logic [2:0] ALU_AND = 3'd1;
  localparam logic [2:0] ALU_EOR = 3'd2;
  localparam logic [2:0] ALU_ADC = 3'd3;
  localparam logic [2:0] ALU_ASL = 3'd4;
  localparam logic [2:0] ALU_LSR = 3'd5;
  localparam logic [2:0] ALU_ROL = 3'd6;
  localparam logic [2:0] ALU_ROR = 3'd7;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

endpackage

// File: rtl/ag6502_nibble_add.sv
// One-nibble adder with carry; decimal correction is present only when
// AG6502_SERIAL_ALU_DECIMAL_EN is defined.
module ag6502_nibble_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  input  logic       dec,
  input  logic       sub,
  output logic [3:0] s,
  output logic       c_out
);

  logic [4:0] raw;

  assign raw = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};

`ifdef AG6502_SERIAL_ALU_DECIMAL_EN
  // b arrives already inverted when subtracting, so a missing nibble carry means a borrow
  always_comb begin
    s     = raw[3:0];
    c_out = raw[4];
    if (dec && !sub && (raw > 5'd9)) begin
      s     = raw[3:0] + 4'd6;
      c_out = 1'b1;
    end else if (dec && sub && !raw[4]) begin
      s     = raw[3:0] + 4'd10;
      c_out = 1'b0;
    end
  end
`else
  logic unused_mode;

  assign unused_mode = dec ^ sub;
  assign s           = raw[3:0];
  assign c_out       = raw[4];
`endif

endmodule

// File: rtl/ag6502_serial_alu.sv
// Nibble-serial 6502-style ALU: logic/shift ops in one EXEC cycle, ADC one nibble
// per cycle. Decimal mode requires AG6502_SERIAL_ALU_DECIMAL_EN.
module ag6502_serial_alu
  import ag6502_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             baseclk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             neg,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             d_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             c_out,
  output logic             v_out,
  output logic             z_out,
  output logic             n_out
);

  localparam int NIB = WIDTH / 4;
  localparam logic [3:0] LAST_NIB = 4'(NIB - 1);

  state_t           state;
  logic [2:0]       op_q;
  logic             dec_q;
  logic             sub_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       nib_cnt;
  logic             a_msb;
  logic             b_msb;
  logic [3:0]       nib_sum;
  logic             nib_carry;
  logic [WIDTH-1:0] fin_r;
  logic             fin_c;
  logic             fin_v;
  logic             last_step;

  ag6502_nibble_add u_nibble_add (
    .a     (a_q[3:0]),
    .b     (b_q[3:0]),
    .c_in  (carry_q),
    .dec   (dec_q),
    .sub   (sub_q),
    .s     (nib_sum),
    .c_out (nib_carry)
  );

  // a_q doubles as the ADC result accumulator: sums enter at the top as operand nibbles leave the bottom
  always_comb begin
    fin_r     = a_q;
    fin_c     = 1'b0;
    last_step = 1'b1;
    case (op_q)
      ALU_ORA: fin_r = a_q | b_q;
      ALU_AND: fin_r = a_q & b_q;
      ALU_EOR: fin_r = a_q ^ b_q;
      ALU_ADC: begin
        fin_r     = {nib_sum, a_q[WIDTH-1:4]};
        fin_c     = nib_carry;
        last_step = (nib_cnt == LAST_NIB);
      end
      ALU_ASL: begin
        fin_r = {a_q[WIDTH-2:0], 1'b0};
        fin_c = a_q[WIDTH-1];
      end
      ALU_LSR: begin
        fin_r = {1'b0, a_q[WIDTH-1:1]};
        fin_c = a_q[0];
      end
      ALU_ROL: begin
        fin_r = {a_q[WIDTH-2:0], carry_q};
        fin_c = a_q[WIDTH-1];
      end
      ALU_ROR: begin
        fin_r = {carry_q, a_q[WIDTH-1:1]};
        fin_c = a_q[0];
      end
      default: ;
    endcase
    fin_v = (op_q == ALU_ADC) && (a_msb == b_msb) && (a_msb != fin_r[WIDTH-1]);
  end

`ifndef AG6502_SERIAL_ALU_DECIMAL_EN
  logic unused_din;

  assign unused_din = d_in;
`endif

  always_ff @(posedge baseclk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      r       <= '0;
      c_out   <= 1'b0;
      v_out   <= 1'b0;
      z_out   <= 1'b1;
      n_out   <= 1'b0;
      nib_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            sub_q   <= neg;
            a_q     <= a;
            b_q     <= neg ? ~b : b;
            carry_q <= c_in;
`ifdef AG6502_SERIAL_ALU_DECIMAL_EN
            dec_q   <= d_in;
`else
            dec_q   <= 1'b0;
`endif
            a_msb   <= a[WIDTH-1];
            b_msb   <= neg ? ~b[WIDTH-1] : b[WIDTH-1];
            nib_cnt <= '0;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (last_step) begin
            r     <= fin_r;
            c_out <= fin_c;
            v_out <= fin_v;
            z_out <= (fin_r == '0);
            n_out <= fin_r[WIDTH-1];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            a_q     <= {nib_sum, a_q[WIDTH-1:4]};
            b_q     <= b_q >> 4;
            carry_q <= nib_carry;
            nib_cnt <= nib_cnt + 4'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ag6502_serial_alu.sv
// Self-checking bench for ag6502_serial_alu (WIDTH=16); decimal expectations
// follow whether AG6502_SERIAL_ALU_DECIMAL_EN is defined.
module tb_ag6502_serial_alu;
  import ag6502_pkg::*;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;
`ifdef AG6502_SERIAL_ALU_DECIMAL_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic             baseclk;
  logic             rst;
  logic             start;
  logic [2:0]       op;
  logic             neg;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             d_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] r;
  logic             c_out;
  logic             v_out;
  logic             z_out;
  logic             n_out;

  ag6502_serial_alu #(.WIDTH(WIDTH)) dut (
    .baseclk (baseclk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .neg     (neg),
    .a       (a),
    .b       (b),
    .c_in    (c_in),
    .d_in    (d_in),
    .busy    (busy),
    .done    (done),
    .r       (r),
    .c_out   (c_out),
    .v_out   (v_out),
    .z_out   (z_out),
    .n_out   (n_out)
  );

  initial baseclk = 1'b0;
  always #5 baseclk = ~baseclk;

  typedef struct {
    logic [2:0]       op;
    logic             neg;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             din;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    logic             z;
    logic             n;
    int               lat;
  } vec_t;

  vec_t vecs[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   chk_en     = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference result {v, c, r} straight from the arithmetic definition of each op
  function automatic logic [WIDTH+1:0] refAlu(input logic [2:0] f, input logic ng,
                                              input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic ci, input logic di);
    logic [WIDTH-1:0] yb;
    logic [WIDTH-1:0] res;
    logic             cy;
    logic             ov;
    int               d;
    yb  = ng ? ~y : y;
    res = '0;
    cy  = 1'b0;
    ov  = 1'b0;
    case (f)
      ALU_ORA: res = x | yb;
      ALU_AND: res = x & yb;
      ALU_EOR: res = x ^ yb;
      ALU_ADC: begin
        if (di && DEC) begin
          cy = ci;
          for (int i = 0; i < NIB; i++) begin
            d = int'(x[4*i +: 4]) + int'(yb[4*i +: 4]) + int'(cy);
            if (!ng) begin
              if (d > 9) begin d = d + 6; cy = 1'b1; end
              else cy = 1'b0;
            end else begin
              if (d < 16) begin d = d + 10; cy = 1'b0; end
              else cy = 1'b1;
            end
            res[4*i +: 4] = 4'(d % 16);
          end
        end else begin
          {cy, res} = {1'b0, x} + {1'b0, yb} + {{WIDTH{1'b0}}, ci};
        end
        ov = (x[WIDTH-1] == yb[WIDTH-1]) && (x[WIDTH-1] != res[WIDTH-1]);
      end
      ALU_ASL: {cy, res} = {x, 1'b0};
      ALU_LSR: {res, cy} = {1'b0, x};
      ALU_ROL: {cy, res} = {x, ci};
      ALU_ROR: {res, cy} = {ci, x};
      default: ;
    endcase
    return {ov, cy, res};
  endfunction

  // Cycle-level model of the handshake: accept in idle, count down the latency, pulse done
  bit               m_busy;
  bit               m_done;
  int               m_left;
  logic [WIDTH-1:0] m_r;
  logic             m_c;
  logic             m_v;
  logic [WIDTH+1:0] pend;

  always @(posedge baseclk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_left = 0;
      m_r = '0; m_c = 1'b0; m_v = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        {m_v, m_c, m_r} = pend;
      end
    end else if (start) begin
      pend   = refAlu(op, neg, a, b, c_in, d_in);
      m_left = (op == ALU_ADC) ? NIB : 1;
      m_busy = 1'b1;
    end
  end

  always @(negedge baseclk) begin
    if (chk_en) begin
      checkOutput("busy", busy, m_busy);
      checkOutput("done", done, m_done);
      checkOutput("r", r, m_r);
      checkOutput("c_out", c_out, m_c);
      checkOutput("v_out", v_out, m_v);
      checkOutput("z_out", z_out, m_r == '0);
      checkOutput("n_out", n_out, m_r[WIDTH-1]);
    end
  end

  task automatic waitDone(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge baseclk);
      #1;
      if (done) begin
        lat = k + 1;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input int idx);
    vec_t v;
    int   lat;
    v = vecs[idx];
    @(posedge baseclk);
    #1;
    op = v.op; neg = v.neg; a = v.a; b = v.b; c_in = v.cin; d_in = v.din;
    start = 1'b1;
    @(posedge baseclk);
    #1;
    start = 1'b0;
    waitDone(lat);
    checkOutput($sformatf("vec%0d_latency", idx), lat, v.lat);
    checkOutput($sformatf("vec%0d_r", idx), r, v.r);
    checkOutput($sformatf("vec%0d_c", idx), c_out, v.c);
    checkOutput($sformatf("vec%0d_v", idx), v_out, v.v);
    checkOutput($sformatf("vec%0d_z", idx), z_out, v.z);
    checkOutput($sformatf("vec%0d_n", idx), n_out, v.n);
  endtask

  initial begin
    int lat;
    //           op       neg   a         b         cin   din   r                                c                v     z                n                lat
    vecs.push_back('{ALU_ADC, 1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555,                        1'b0,            1'b0, 1'b0,            1'b0,            5});
    vecs.push_back('{ALU_ADC, 1'b0, 16'h0999, 16'h0001, 1'b0, 1'b1, DEC ? 16'h1000 : 16'h099A,       1'b0,            1'b0, 1'b0,            1'b0,            5});
    vecs.push_back('{ALU_ADC, 1'b0, 16'h9999, 16'h0001, 1'b0, 1'b1, DEC ? 16'h0000 : 16'h999A,       DEC,             1'b0, DEC,             !DEC,            5});
    vecs.push_back('{ALU_ADC, 1'b1, 16'h1000, 16'h0001, 1'b1, 1'b1, DEC ? 16'h0999 : 16'h0FFF,       1'b1,            1'b0, 1'b0,            1'b0,            5});
    vecs.push_back('{ALU_ADC, 1'b0, 16'h0045, 16'h0038, 1'b0, 1'b1, DEC ? 16'h0083 : 16'h007D,       1'b0,            1'b0, 1'b0,            1'b0,            5});
    vecs.push_back('{ALU_ADC, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000,                        1'b0,            1'b1, 1'b0,            1'b1,            5});
    vecs.push_back('{ALU_ADC, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000,                        1'b1,            1'b0, 1'b1,            1'b0,            5});
    vecs.push_back('{ALU_ADC, 1'b1, 16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002,                        1'b1,            1'b0, 1'b0,            1'b0,            5});
    vecs.push_back('{ALU_ROR, 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h8000,                        1'b1,            1'b0, 1'b0,            1'b1,            2});
    vecs.push_back('{ALU_ASL, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b0, 16'h0000,                        1'b1,            1'b0, 1'b1,            1'b0,            2});
    vecs.push_back('{ALU_LSR, 1'b0, 16'h8001, 16'h0000, 1'b1, 1'b0, 16'h4000,                        1'b1,            1'b0, 1'b0,            1'b0,            2});
    vecs.push_back('{ALU_ROL, 1'b0, 16'h8001, 16'h0000, 1'b0, 1'b0, 16'h0002,                        1'b1,            1'b0, 1'b0,            1'b0,            2});
    vecs.push_back('{ALU_ORA, 1'b0, 16'h1234, 16'h0008, 1'b1, 1'b1, 16'h123C,                        1'b0,            1'b0, 1'b0,            1'b0,            2});
    vecs.push_back('{ALU_AND, 1'b0, 16'hF0F0, 16'hFF00, 1'b0, 1'b0, 16'hF000,                        1'b0,            1'b0, 1'b0,            1'b1,            2});
    vecs.push_back('{ALU_EOR, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0000,                        1'b0,            1'b0, 1'b1,            1'b0,            2});

    rst = 1'b1; start = 1'b0; op = ALU_ORA; neg = 1'b0;
    a = '0; b = '0; c_in = 1'b0; d_in = 1'b0;
    repeat (2) @(posedge baseclk);
    #1;
    chk_en = 1'b1;
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_r", r, 16'h0000);
    checkOutput("reset_c", c_out, 1'b0);
    checkOutput("reset_v", v_out, 1'b0);
    checkOutput("reset_z", z_out, 1'b1);
    checkOutput("reset_n", n_out, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(i);

    // A start held high with a different op while busy must not disturb the ADC in flight
    @(posedge baseclk);
    #1;
    op = ALU_ADC; neg = 1'b0; a = 16'h1234; b = 16'h4321; c_in = 1'b0; d_in = 1'b0;
    start = 1'b1;
    @(posedge baseclk);
    #1;
    op = ALU_ORA; a = 16'hFFFF; b = 16'hFFFF;
    waitDone(lat);
    start = 1'b0;
    checkOutput("ignore_latency", lat, 5);
    checkOutput("ignore_r", r, 16'h5555);

    // Reset during the second EXEC cycle aborts the ADC without a done pulse
    @(posedge baseclk);
    #1;
    op = ALU_ADC; a = 16'h0045; b = 16'h0038; start = 1'b1;
    @(posedge baseclk);
    #1;
    start = 1'b0;
    @(posedge baseclk);
    #1;
    rst = 1'b1;
    @(posedge baseclk);
    #1;
    rst = 1'b0;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_done", done, 1'b0);
    checkOutput("abort_r", r, 16'h0000);
    checkOutput("abort_z", z_out, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(posedge baseclk);
      #1;
      checkOutput("abort_no_done", done, 1'b0);
    end

    // Reset wins over a simultaneous start
    rst = 1'b1; start = 1'b1; op = ALU_ADC; a = 16'h1111; b = 16'h2222;
    @(posedge baseclk);
    #1;
    rst = 1'b0; start = 1'b0;
    checkOutput("rst_priority_busy", busy, 1'b0);

    applyStimulus(0);

    repeat (2) @(posedge baseclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ag6502_serial_alu.md
AG6502_SERIAL_ALU -- requirements
Module: ag6502_serial_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand width in bits; legal values are multiples of 4 from 8 to 64.
REQ-002 SHALL derive NIB = WIDTH/4 as the nibble count.
REQ-003 SHALL have port baseclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request; accepted only in IDLE.
REQ-006 SHALL have port op, input, 3 bits: ORA=0, AND=1, EOR=2, ADC=3, ASL=4, LSR=5, ROL=6, ROR=7.
REQ-007 SHALL have port neg, input, 1 bit: subtract mode; b is inverted internally for ADC.
REQ-008 SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-009 SHALL have ports c_in and d_in, input, 1 bit each: carry in and decimal-mode request.
REQ-010 SHALL have ports busy and done, output, 1 bit each: busy is high during an operation; done is a one-cycle completion pulse.
REQ-011 SHALL have port r, output, WIDTH bits: result; and ports c_out, v_out, z_out, n_out, output, 1 bit each: flags.

Function
REQ-012 SHALL implement the state machine IDLE -> EXEC -> DONE -> IDLE, with ADC looping in EXEC.
REQ-013 SHALL, on start in IDLE, latch op, neg, a, b (inverted when neg=1), c_in and d_in, enter EXEC, and raise busy.
REQ-014 SHALL complete non-ADC ops in one EXEC cycle: done is high in the 2nd cycle after the start edge.
REQ-015 SHALL process ADC one nibble per EXEC cycle, LSB first, with the carry chained through a register.
REQ-016 SHALL raise done for ADC in cycle NIB+1 after the start edge.
REQ-017 SHALL hold busy high from the start edge until the edge that raises done.
REQ-018 SHALL ignore start while busy or done is high.
REQ-019 SHALL accept start in the cycle immediately after done.
REQ-020 SHALL hold r and the flags stable from done until the next accepted start.
REQ-021 SHALL apply decimal correction per nibble when d_in=1:
- add: nibble sum > 9 -> add 6 and carry out 1;
- subtract: no nibble carry -> add 10 (mod 16) and carry out 0.
REQ-022 SHALL take c_out as the final carry for ADC.
REQ-023 SHALL take c_out as the bit shifted out for shifts: a[WIDTH-1] for ASL/ROL, a[0] for LSR/ROR.
REQ-024 SHALL rotate c_in into the vacated bit for ROL/ROR, and shift in 0 for ASL/LSR.
REQ-025 SHALL leave c_out = 0 for ORA/AND/EOR.
REQ-026 SHALL set v_out = (a[msb]==b'[msb]) && (a[msb]!=r[msb]) for ADC, where b' is the inverted-if-neg operand, and v_out = 0 otherwise.
REQ-027 SHALL set z_out = (r==0) and n_out = r[WIDTH-1].
REQ-028 SHALL treat an invalid d_in with a non-ADC op as ignored.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, force state IDLE; busy=0, done=0, r=0, c_out=v_out=n_out=0, z_out=1.
REQ-030 SHALL abort any operation in progress on rst=1, producing no done pulse.
REQ-031 SHALL give rst priority over a simultaneous start.

Configuration
REQ-032 SHALL, with macro AG6502_SERIAL_ALU_DECIMAL_EN defined, implement the decimal correction of REQ-021.
REQ-033 SHALL, without the macro, omit the decimal logic, treat d_in as 0, and keep all other behaviour and latency identical.

Structure
REQ-034 SHALL place in shared package ag6502_pkg:
- the op encoding constants (matching the core's ALU_* values);
- the state enum (IDLE, EXEC, DONE).
REQ-035 SHALL instantiate one sub-module, ag6502_nibble_add: a 4-bit adder plus carry and optional decimal correction, combinational, used once per EXEC cycle.

Verification (WIDTH=16)
REQ-036 SHALL check: ADC a=0x1234 b=0x4321 c_in=0 d_in=0 -> done in cycle 5, r=0x5555, c=0, v=0, z=0, n=0.
REQ-037 SHALL check: ADC d_in=1 a=0x0999 b=0x0001 c_in=0 -> r=0x1000, c=0; then a=0x9999 b=0x0001 -> r=0x0000, c=1, z=1.
REQ-038 SHALL check: ADC neg=1 d_in=1 a=0x1000 b=0x0001 c_in=1 -> r=0x0999, c=1; and binary a=0x7FFF b=0x0001 -> r=0x8000, v=1, n=1.
REQ-039 SHALL check: ROR a=0x0001 c_in=1 -> done in cycle 2, r=0x8000, c=1, n=1; and ASL a=0x8000 -> r=0x0000, c=1, z=1.
REQ-040 SHALL check: start during busy is ignored; rst asserted in EXEC cycle 2 -> next cycle busy=0, no done, r=0, z=1.
REQ-041 SHALL check, built without the macro: decimal vector 0x0999+0x0001 d_in=1 -> r=0x099A.
